status_uart_reporter: RTL and testbench

- Sits directly downstream of the sound-box top level, in the clk27 (FPGA) domain.
- Consumes the decoded keycode stream (latest_keycode/latest_keycode_valid) and the attenuation result (is_muted/volume_db/volume_db_valid).
- Queues keycodes, coalesces volume updates, and serialises both as checksummed 5-byte frames on an 8N1 UART line to the board MCU.

---
 rtl/status_uart_reporter.sv | 212 +++++++++++++++++++++
 tb/tb_status_uart_reporter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_uart_reporter.sv
// -----------------------------------------------------------------------------
// status_uart_reporter
//   Queues decoded keycodes and coalesces volume/mute updates. Each queued item
//   is sent to the board MCU as a 5-byte frame on an 8N1 UART line:
//     0xA5, TYPE, B2, B3, CHK    (CHK = TYPE ^ B2 ^ B3)
//     keycode : TYPE=0x01, B2=keycode[15:8], B3=keycode[7:0]
//     volume  : TYPE=0x02, B2={is_muted,3'b000,volume_db[11:8]}, B3=volume_db[7:0]
//   When a keycode and a volume update are both waiting, the type opposite to
//   the previously sent one goes first, so neither can starve.
//
// Ports
//   clk27           : FPGA system clock
//   hw_reset_n      : asynchronous active-low reset
//   keycode         : keycode payload, sampled when keycode_valid=1
//   keycode_valid   : single-cycle keycode strobe
//   is_muted        : mute flag, sampled with volume_db_valid
//   volume_db       : {L[5:0], R[5:0]} attenuation
//   volume_db_valid : single-cycle volume strobe
//   uart_tx         : serial out, idle high (registered)
//   busy            : high while a frame is on the line
//   fifo_level      : keycode FIFO occupancy
//   fifo_overflow   : sticky, a keycode was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module status_uart_reporter #(
  parameter int BAUD_DIV   = 234,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk27,
  input  logic              hw_reset_n,
  input  logic [15:0]       keycode,
  input  logic              keycode_valid,
  input  logic              is_muted,
  input  logic [11:0]       volume_db,
  input  logic              volume_db_valid,
  output logic              uart_tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_overflow
);

  localparam int                CNT_W       = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0]  BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [ADDR_W:0]   DEPTH_LVL   = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  typedef enum logic       {SENT_KEY, SENT_VOL}              sent_t;

  state_t              state_q, state_d;
  sent_t               last_q;
  logic [CNT_W-1:0]    baud_q;
  logic [2:0]          bit_q;
  logic [2:0]          byte_q;
  logic [39:0]         frame_q, frame_d;
  logic                tx_q, tx_d, busy_q;

  logic [15:0]         mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q;
  logic                overflow_q;
  logic [12:0]         vol_q;          // {is_muted, volume_db}
  logic                vol_pending_q;

  logic                kc_pending, pick_kc, start_frame, kc_capture, vol_capture;
  logic                baud_done, wr_en, rd_en;
  logic [7:0]          f_type, f_b2, f_b3;

  // ---------------------------------------------------------------------------
  // Arbitration: only meaningful in IDLE, where start_frame can fire.
  // ---------------------------------------------------------------------------
  assign kc_pending  = (level_q != '0);
  assign pick_kc     = kc_pending && (!vol_pending_q || last_q == SENT_VOL);
  assign start_frame = (state_q == S_IDLE) && (kc_pending || vol_pending_q);
  assign kc_capture  = start_frame && pick_kc;
  assign vol_capture = start_frame && !pick_kc;
  assign baud_done   = (baud_q == '0);

  assign wr_en = keycode_valid && (level_q != DEPTH_LVL);
  assign rd_en = kc_capture;

  // Frame assembly; byte 0 (0xA5) sits in the LSBs so the line simply shifts
  // the register right one bit per data bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    f_type = 8'h02;
    f_b2   = {vol_q[12], 3'b000, vol_q[11:8]};
    f_b3   = vol_q[7:0];
    if (pick_kc) begin
      f_type = 8'h01;
      f_b2   = mem[rd_ptr_q][15:8];
      f_b3   = mem[rd_ptr_q][7:0];
    end
    frame_d = {f_type ^ f_b2 ^ f_b3, f_b3, f_b2, f_type, 8'hA5};
  end

  // ---------------------------------------------------------------------------
  // Line FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk27 or negedge hw_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!hw_reset_n) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE:  if (start_frame) state_d = S_START;
      S_START: begin
        tx_d = 1'b0;
        if (baud_done) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = frame_q[0];
        if (baud_done && bit_q == 3'd7) state_d = S_STOP;
      end
      S_STOP:  if (baud_done) state_d = (byte_q == 3'd4) ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters and frame shifter. The baud counter is parked at its reload value
  // in IDLE so the first start bit gets a full BAUD_DIV cycles.
  always_ff @(posedge clk27 or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      baud_q  <= BAUD_RELOAD;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      last_q  <= SENT_VOL;
    end else if (state_q == S_IDLE) begin
      baud_q <= BAUD_RELOAD;
      bit_q  <= '0;
      byte_q <= '0;
      if (start_frame) begin
        frame_q <= frame_d;
        last_q  <= pick_kc ? SENT_KEY : SENT_VOL;
      end
    end else begin
      baud_q <= baud_done ? BAUD_RELOAD : baud_q - 1'b1;
      if (state_q == S_DATA && baud_done) begin
        frame_q <= frame_q >> 1;
        bit_q   <= bit_q + 3'd1;   // wraps 7->0 exactly as the byte ends
      end
      if (state_q == S_STOP && baud_done) byte_q <= byte_q + 3'd1;
    end
  end

  // Line and busy are registered from the state, which puts the start bit two
  // edges after the strobe and keeps busy aligned with the line activity.
  always_ff @(posedge clk27 or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= (state_q != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Keycode FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; only pointers and level need one,
  // and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk27) begin
    if (wr_en) mem[wr_ptr_q] <= keycode;
  end

  always_ff @(posedge clk27 or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // A full FIFO drops the write even when a read frees a slot this cycle.
      if (keycode_valid && level_q == DEPTH_LVL) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Volume holding register: a new strobe always wins over a same-cycle capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk27 or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      vol_q         <= '0;
      vol_pending_q <= 1'b0;
    end else if (volume_db_valid) begin
      vol_q         <= {is_muted, volume_db};
      vol_pending_q <= 1'b1;
    end else if (vol_capture) begin
      vol_pending_q <= 1'b0;
    end
  end

  assign uart_tx       = tx_q;
  assign busy          = busy_q;
  assign fifo_level    = level_q;
  assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_status_uart_reporter.sv
// -----------------------------------------------------------------------------
// tb_status_uart_reporter
//   Drives keycode / volume strobes, decodes the UART line with a bit-level
//   receiver, and compares the received bytes with frames built by a queue-based
//   model of the reporter (FIFO order, volume coalescing, type alternation).
// -----------------------------------------------------------------------------
module tb_status_uart_reporter;

  localparam int BD     = 4;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic          clk27 = 1'b0;
  logic          hw_reset_n;
  logic [15:0]   keycode;
  logic          keycode_valid;
  logic          is_muted;
  logic [11:0]   volume_db;
  logic          volume_db_valid;
  logic          uart_tx;
  logic          busy;
  logic [AW:0]   fifo_level;
  logic          fifo_overflow;

  int tests_run = 0;
  int failures  = 0;

  logic [7:0]  rx_bytes[$];
  logic [7:0]  exp_bytes[$];
  int          mon_err = 0;

  // model state
  logic [15:0] model_kq[$];
  bit          model_vol_pend;
  logic        model_vol_m;
  logic [11:0] model_vol_v;

  status_uart_reporter #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk27           (clk27),
    .hw_reset_n      (hw_reset_n),
    .keycode         (keycode),
    .keycode_valid   (keycode_valid),
    .is_muted        (is_muted),
    .volume_db       (volume_db),
    .volume_db_valid (volume_db_valid),
    .uart_tx         (uart_tx),
    .busy            (busy),
    .fifo_level      (fifo_level),
    .fifo_overflow   (fifo_overflow)
  );

  always #5 clk27 = ~clk27;

  // UART receiver: every bit must hold steady for BD samples; start=0, stop=1.
  initial begin
    int c;
    int j;
    logic cur;
    logic [7:0] sh;
    bit bad;
    c = -1; cur = 1'b1; sh = '0; bad = 0;
    forever begin
      @(negedge clk27);
      if (hw_reset_n !== 1'b1) c = -1;
      else begin
        if (c < 0 && uart_tx === 1'b0) begin c = 0; bad = 0; end
        else if (c >= 0) c++;
        if (c >= 0) begin
          if (c % BD == 0) cur = uart_tx;
          else if (uart_tx !== cur) bad = 1;
          if (c % BD == BD - 1) begin
            j = c / BD;
            if (j == 0) begin
              if (cur !== 1'b0) bad = 1;
            end else if (j <= 8) begin
              sh[j-1] = cur;
            end else begin
              if (cur !== 1'b1) bad = 1;
              if (bad) mon_err++;
              else rx_bytes.push_back(sh);
              c = -1;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  task automatic add_frame(input bit is_vol, input logic [15:0] kc,
                           input logic m, input logic [11:0] v);
    logic [7:0] t, b2, b3;
    if (is_vol) begin t = 8'h02; b2 = {m, 3'b000, v[11:8]}; b3 = v[7:0]; end
    else        begin t = 8'h01; b2 = kc[15:8];            b3 = kc[7:0]; end
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(t);
    exp_bytes.push_back(b2);
    exp_bytes.push_back(b3);
    exp_bytes.push_back(t ^ b2 ^ b3);
  endtask

  // Drain the model's pending work in the order the arbiter must choose.
  task automatic model_schedule(input bit last_was_vol);
    bit lv;
    lv = last_was_vol;
    while (model_kq.size() > 0 || model_vol_pend) begin
      if (model_kq.size() > 0 && (!model_vol_pend || lv)) begin
        add_frame(1'b0, model_kq.pop_front(), 1'b0, 12'h000);
        lv = 1'b0;
      end else begin
        add_frame(1'b1, 16'h0000, model_vol_m, model_vol_v);
        model_vol_pend = 0;
        lv = 1'b1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic strobe(input bit dk, input logic [15:0] k,
                        input bit dv, input logic m, input logic [11:0] v);
    @(negedge clk27);
    keycode = k; keycode_valid = dk;
    is_muted = m; volume_db = v; volume_db_valid = dv;
    @(negedge clk27);
    keycode_valid = 1'b0; volume_db_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int idle, cyc;
    idle = 0; cyc = 0;
    while (idle < 4 && cyc < 20000) begin
      @(negedge clk27);
      cyc++;
      idle = (busy === 1'b0) ? idle + 1 : 0;
    end
    if (idle < 4) begin
      tests_run++; failures++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, cyc);
    end
  endtask

  task automatic clear_queues();
    rx_bytes.delete();
    exp_bytes.delete();
    model_kq.delete();
    model_vol_pend = 0;
    mon_err = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    hw_reset_n = 1'b0;
    keycode = '0; keycode_valid = 1'b0;
    is_muted = 1'b0; volume_db = '0; volume_db_valid = 1'b0;
    repeat (3) @(negedge clk27);
    tests_run++;
    if ({uart_tx, busy, fifo_level, fifo_overflow} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: tx=%b busy=%b level=%0d ovf=%b, required 1 0 0 0",
               uart_tx, busy, fifo_level, fifo_overflow);
    end
    hw_reset_n = 1'b1;
    repeat (3) @(negedge clk27);
    tests_run++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: tx=%b busy=%b, required 1 0", uart_tx, busy);
    end
    clear_queues();
  endtask

  task automatic test_keycode_frame();
    int bcnt;
    clear_queues();
    strobe(1'b1, 16'h1234, 1'b0, 1'b0, 12'h000);    // sampled at edge N
    @(negedge clk27);                               // after edge N+1
    tests_run++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL kc_latency_n1: tx=%b busy=%b, required 1 0", uart_tx, busy);
    end
    @(negedge clk27);                               // after edge N+2
    tests_run++;
    if (uart_tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL kc_latency_n2: tx=%b busy=%b, required 0 1", uart_tx, busy);
    end
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (busy === 1'b1 && bcnt < 1000) begin
      @(negedge clk27);
      if (busy === 1'b1) bcnt++;
    end
    tests_run++;
    if (bcnt != 50 * BD) begin
      failures++;
      $display("FAIL kc_busy_len: got %0d cycles, required %0d", bcnt, 50 * BD);
    end
    wait_drain("kc");
    add_frame(1'b0, 16'h1234, 1'b0, 12'h000);
    tests_run++;
    if (rx_bytes.size() != exp_bytes.size() || mon_err != 0) begin
      failures++;
      $display("FAIL kc_frame_len: got %0d bytes (%0d framing errors), required %0d",
               rx_bytes.size(), mon_err, exp_bytes.size());
    end else foreach (exp_bytes[i]) begin
      tests_run++;
      if (rx_bytes[i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL kc_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_volume_frame();
    clear_queues();
    strobe(1'b0, 16'h0000, 1'b1, 1'b1, 12'h2C5);
    wait_drain("vol");
    add_frame(1'b1, 16'h0000, 1'b1, 12'h2C5);
    tests_run++;
    if (rx_bytes.size() != exp_bytes.size() || mon_err != 0) begin
      failures++;
      $display("FAIL vol_frame_len: got %0d bytes (%0d framing errors), required %0d",
               rx_bytes.size(), mon_err, exp_bytes.size());
    end else foreach (exp_bytes[i]) begin
      tests_run++;
      if (rx_bytes[i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL vol_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_coalesce();
    clear_queues();
    strobe(1'b1, 16'hBEEF, 1'b0, 1'b0, 12'h000);
    add_frame(1'b0, 16'hBEEF, 1'b0, 12'h000);
    repeat (10) @(negedge clk27);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0, 12'h000);
    repeat (20) @(negedge clk27);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0, 12'h041);
    model_vol_pend = 1; model_vol_m = 1'b0; model_vol_v = 12'h041;
    model_schedule(1'b0);
    wait_drain("coalesce");
    tests_run++;
    if (rx_bytes.size() != exp_bytes.size() || mon_err != 0) begin
      failures++;
      $display("FAIL coalesce_len: got %0d bytes (%0d framing errors), required %0d",
               rx_bytes.size(), mon_err, exp_bytes.size());
    end else foreach (exp_bytes[i]) begin
      tests_run++;
      if (rx_bytes[i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL coalesce_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    clear_queues();
    strobe(1'b1, 16'hA0A0, 1'b0, 1'b0, 12'h000);
    add_frame(1'b0, 16'hA0A0, 1'b0, 12'h000);
    repeat (5) @(negedge clk27);
    strobe(1'b1, 16'hB1B1, 1'b0, 1'b0, 12'h000);
    strobe(1'b1, 16'hC2C2, 1'b0, 1'b0, 12'h000);
    model_kq.push_back(16'hB1B1);
    model_kq.push_back(16'hC2C2);
    tests_run++;
    if (fifo_level !== 4'(model_kq.size())) begin
      failures++;
      $display("FAIL arb_level: got %0d, required %0d", fifo_level, model_kq.size());
    end
    strobe(1'b0, 16'h0000, 1'b1, 1'b1, 12'h3AB);
    model_vol_pend = 1; model_vol_m = 1'b1; model_vol_v = 12'h3AB;
    model_schedule(1'b0);
    wait_drain("arb");
    tests_run++;
    if (rx_bytes.size() != exp_bytes.size() || mon_err != 0) begin
      failures++;
      $display("FAIL arb_len: got %0d bytes (%0d framing errors), required %0d",
               rx_bytes.size(), mon_err, exp_bytes.size());
    end else foreach (exp_bytes[i]) begin
      tests_run++;
      if (rx_bytes[i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL arb_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] burst[12];
    clear_queues();
    foreach (burst[i]) burst[i] = 16'($urandom);
    tests_run++;
    if (fifo_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pre: got %b, required 0", fifo_overflow);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk27);
      keycode = burst[i]; keycode_valid = 1'b1;
    end
    @(negedge clk27);
    keycode_valid = 1'b0;
    // First entry is popped the cycle after it lands, so 9 fit and 3 drop.
    for (int i = 0; i < DEPTH + 1; i++) model_kq.push_back(burst[i]);
    tests_run++;
    if (fifo_level !== 4'(DEPTH) || fifo_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_burst: level=%0d ovf=%b, required %0d 1", fifo_level, fifo_overflow, DEPTH);
    end
    model_schedule(1'b0);
    wait_drain("ovf");
    tests_run++;
    if (fifo_overflow !== 1'b1 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b level=%0d, required 1 0", fifo_overflow, fifo_level);
    end
    tests_run++;
    if (rx_bytes.size() != exp_bytes.size() || mon_err != 0) begin
      failures++;
      $display("FAIL ovf_len: got %0d bytes (%0d framing errors), required %0d",
               rx_bytes.size(), mon_err, exp_bytes.size());
    end else foreach (exp_bytes[i]) begin
      tests_run++;
      if (rx_bytes[i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL ovf_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    clear_queues();
    strobe(1'b1, 16'h0000, 1'b0, 1'b0, 12'h000);   // byte 2 is all zeros
    strobe(1'b1, 16'h1111, 1'b0, 1'b0, 12'h000);
    strobe(1'b1, 16'h2222, 1'b0, 1'b0, 12'h000);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0, 12'h7FF);
    cyc = 0;
    while (rx_bytes.size() < 2 && cyc < 2000) begin
      @(negedge clk27);
      cyc++;
    end
    if (rx_bytes.size() < 2) begin
      tests_run++; failures++;
      $display("FAIL rst_mid_wait: got %0d bytes, required 2", rx_bytes.size());
    end
    repeat (14) @(negedge clk27);                  // inside data bit 2 of byte 2
    tests_run++;
    if (uart_tx !== 1'b0 || busy !== 1'b1 || fifo_level !== 4'd2) begin
      failures++;
      $display("FAIL rst_mid_pre: tx=%b busy=%b level=%0d, required 0 1 2", uart_tx, busy, fifo_level);
    end
    #1 hw_reset_n = 1'b0;
    #1;
    tests_run++;
    if ({uart_tx, busy, fifo_level, fifo_overflow} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_async: tx=%b busy=%b level=%0d ovf=%b, required 1 0 0 0",
               uart_tx, busy, fifo_level, fifo_overflow);
    end
    repeat (2) @(negedge clk27);
    hw_reset_n = 1'b1;
    clear_queues();
    // Pending volume was discarded and last type restarts as volume, so a
    // same-cycle keycode + volume must go out keycode first, then volume.
    strobe(1'b1, 16'h5A3C, 1'b1, 1'b1, 12'h123);
    model_kq.push_back(16'h5A3C);
    model_vol_pend = 1; model_vol_m = 1'b1; model_vol_v = 12'h123;
    model_schedule(1'b1);
    wait_drain("rst_mid");
    tests_run++;
    if (rx_bytes.size() != exp_bytes.size() || mon_err != 0) begin
      failures++;
      $display("FAIL rst_mid_len: got %0d bytes (%0d framing errors), required %0d",
               rx_bytes.size(), mon_err, exp_bytes.size());
    end else foreach (exp_bytes[i]) begin
      tests_run++;
      if (rx_bytes[i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL rst_mid_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int nk, nv;
    for (int it = 0; it < 8; it++) begin
      clear_queues();
      k = 16'($urandom);
      strobe(1'b1, k, 1'b0, 1'b0, 12'h000);
      add_frame(1'b0, k, 1'b0, 12'h000);
      repeat (5) @(negedge clk27);
      nk = $urandom_range(0, 5);
      nv = $urandom_range(0, 2);
      while (nk > 0 || nv > 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk27);
        if (nk > 0 && (nv == 0 || $urandom_range(0, 1) == 0)) begin
          k = 16'($urandom);
          strobe(1'b1, k, 1'b0, 1'b0, 12'h000);
          model_kq.push_back(k);
          nk--;
        end else begin
          model_vol_m = 1'($urandom);
          model_vol_v = 12'($urandom);
          model_vol_pend = 1;
          strobe(1'b0, 16'h0000, 1'b1, model_vol_m, model_vol_v);
          nv--;
        end
      end
      model_schedule(1'b0);
      wait_drain("rand");
      tests_run++;
      if (rx_bytes.size() != exp_bytes.size() || mon_err != 0) begin
        failures++;
        $display("FAIL rand%0d_len: got %0d bytes (%0d framing errors), required %0d",
                 it, rx_bytes.size(), mon_err, exp_bytes.size());
      end else foreach (exp_bytes[i]) begin
        tests_run++;
        if (rx_bytes[i] !== exp_bytes[i]) begin
          failures++;
          $display("FAIL rand%0d_byte%0d: got %h, required %h", it, i, rx_bytes[i], exp_bytes[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_keycode_frame();
    test_volume_frame();
    test_coalesce();
    test_arbitration();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
